keypad_input_unit: RTL
======================

# keypad_input_unit

Input unit (IU) for the 8-bit two-function calculator. It scans a 4x4 active-low matrix keypad and debounces each press. For every accepted key it emits a one-cycle `trig` pulse with the 4-bit key code on `value`, and it shifts decimal digits into an 8-bit operand register. It sits directly upstream of the calculator control unit, which consumes `trig` and `value`, and clears this block through `ClearIU` between operand entries.

## Interface
- `SCAN_DIV`, default 4: clocks each column is held active during scanning (≥2).
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples needed to accept a press or a release (≥2).
- `clock` (input, 1): system clock, rising edge.
- `ClearAll` (input, 1): **one clock; reset is asynchronous and active-low**. Clears the whole block.
- `ClearIU` (input, 1): synchronous active-low entry clear, driven by the control unit.
- `row` (input, 4): keypad rows, active-low, externally pulled up, asynchronous to `clock`.
- `col` (output, 4): keypad column drive. Exactly one bit is low.
- `value` (output, 4): code of the last accepted key.
- `trig` (output, 1): one-cycle pulse per accepted key.
- `operand` (output, 8): entered operand as two packed BCD digits, `{tens, units}`.
- `busy` (output, 1): high while a key is being debounced or held.

## Operation
- **Row synchronizer.** `row` passes through a 2-flop synchronizer. All decisions use the synchronized `rs`.
- **Key code.** The key code is `{r[1:0], c[1:0]}`.
  - `r` is the index of the single low bit of `rs`.
  - `c` is the index of the low bit of `col`.
  - Codes 0x0–0x9 are digits. 0xA = add, 0xB = sub, 0xF = enter. 0xC–0xE are accepted and reported but have no operand effect.
- **SCAN state**
  - `col` rotates 1110 → 1101 → 1011 → 0111 → 1110, advancing every `SCAN_DIV` clocks.
  - If `rs` has exactly one bit low, latch the row and column, clear the debounce counter, and go to DEBOUNCE. `col` freezes.
  - If `rs` has more than one bit low, ignore it and keep scanning.
- **DEBOUNCE state**
  - Each clock that `rs` equals the latched pattern, increment the counter.
  - Any mismatch returns to SCAN, with the column rotation resuming from the frozen column.
  - When the count reaches `DEBOUNCE_CYCLES`, go to PRESSED.
- **PRESSED state** (exactly one clock)
  - Register `value` = key code and assert `trig` for that clock.
  - If the code is ≤ 9: `operand <= {operand[3:0], code}`. The old tens digit is discarded.
  - Go to WAIT_RELEASE.
- **WAIT_RELEASE state**
  - Requires `rs` == 4'b1111 for `DEBOUNCE_CYCLES` consecutive clocks. Any low bit restarts the count.
  - Then go to SCAN. A held key never retriggers.
- **`busy`** is high in DEBOUNCE, PRESSED and WAIT_RELEASE.
- **ClearIU low** (synchronous; wins over every other update in the same cycle):
  - `operand` = 0, `value` = 0, `trig` = 0, counters = 0.
  - State goes to WAIT_RELEASE, so a key held across the clear is not re-accepted.
  - `col` holds its current value.
- **ClearAll low** (asynchronous):
  - State = SCAN, `col` = 4'b1110, `value` = 0, `trig` = 0, `operand` = 0, `busy` = 0.
  - Synchronizer flops are set to 1, and all counters are cleared.

## Timing
- **Latency.** From the `row` edge to `trig`: 2 synchronizer clocks, plus the column-hit delay (≤ 4·`SCAN_DIV`), plus `DEBOUNCE_CYCLES`, plus 1.
- **Output registration.** `value`, `operand` and `trig` all change on the same rising edge. `value` and `operand` then hold until the next accepted key or a clear.
- **Trig spacing.** `trig` is never high on two consecutive clocks. The minimum spacing between pulses is 2·`DEBOUNCE_CYCLES` + 2 clocks.
- **Scan period.** A full rotation is 4·`SCAN_DIV` clocks when idle.
- **Bounce.** A bounce shorter than `DEBOUNCE_CYCLES` in either direction produces no `trig`.
- **ClearAll released mid-press.** The block starts in SCAN. The press is accepted after full debounce, which is intended.
- **ClearIU vs. PRESSED.** If `ClearIU` is low in the PRESSED cycle, no `trig` is emitted and `operand` stays 0.

## Test plan
- **Reset.** Hold `ClearAll` low with random `row`, then release. Required: `col` = 1110, `value` = 0, `operand` = 0, `trig` low, and `col` advances after 4 clocks.
- **Clean digits.** Press key 0x3 (row 0, col 3) for 40 clocks, release, then press 0x5. Required: two single-cycle `trig` pulses, `value` = 3 then 5, `operand` = 0x03 then 0x35.
- **Bounce rejection.** Toggle row 1 low/high in 5-clock pulses for 60 clocks. Required: no `trig`. Then hold it low 30 clocks. Required: exactly one `trig` with the correct code.
- **Operator key and overflow.** Enter digits 1, 2, 7, then key 0xA. Required: `operand` = 0x27 after the 7. At key 0xA, `value` = 0xA, `trig` pulses, and `operand` stays 0x27.
- **ClearIU while held.** Hold key 0x9 through a 1-cycle `ClearIU` low pulse after its `trig`. Required: `operand` = 0, no second `trig` until release and re-press.
- **Multi-key.** Drive two rows low simultaneously. Required: no `trig`, `busy` stays low, and scanning continues.

Source files
------------

// File: rtl/keypad_input_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keypad_input_unit                                               |
// | Purpose  : Input unit of the 8-bit calculator. Scans a 4x4 active-low      |
// |            matrix keypad, debounces press and release, reports each        |
// |            accepted key as a one-cycle trig pulse with its code on value,  |
// |            and shifts decimal digits into a two-digit BCD operand.         |
// | Ports    : clock    - system clock, rising edge                            |
// |            ClearAll - asynchronous active-low clear of the whole block     |
// |            ClearIU  - synchronous active-low entry clear (control unit)    |
// |            row      - keypad rows, active-low, asynchronous to clock       |
// |            col      - keypad column drive, exactly one bit low             |
// |            value    - code of the last accepted key                        |
// |            trig     - one-cycle pulse per accepted key                     |
// |            operand  - entered operand {tens, units} in BCD                 |
// |            busy     - high while a key is debounced or held                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module keypad_input_unit #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       ClearAll,
  input  logic       ClearIU,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       trig,
  output logic [7:0] operand,
  output logic       busy
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [3:0]       sync1, rs;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       key_row, key_row_n;
  logic [3:0]       key_col, key_col_n;
  logic [3:0]       col_n, value_n;
  logic [7:0]       operand_n;
  logic             trig_n;
  logic [3:0]       key_code;

  // True when exactly one bit of an active-low pattern is low.
  function automatic logic one_low(input logic [3:0] p);
    case (p)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Index of the single low bit of a one-low pattern.
  function automatic logic [1:0] low_index(input logic [3:0] p);
    case (p)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign key_code = {low_index(key_row), low_index(key_col)};
  assign busy     = (state != SCAN);

  // Two-flop synchronizer; idles at "no row pulled low".
  always_ff @(posedge clock or negedge ClearAll) begin
    if (!ClearAll) begin
      sync1 <= 4'hF;
      rs    <= 4'hF;
    end else begin
      sync1 <= row;
      rs    <= sync1;
    end
  end

  always_ff @(posedge clock or negedge ClearAll) begin
    if (!ClearAll) begin
      state   <= SCAN;
      col     <= 4'b1110;
      div_cnt <= '0;
      cnt     <= '0;
      key_row <= 4'hF;
      key_col <= 4'b1110;
      value   <= 4'h0;
      trig    <= 1'b0;
      operand <= 8'h00;
    end else begin
      state   <= state_n;
      col     <= col_n;
      div_cnt <= div_cnt_n;
      cnt     <= cnt_n;
      key_row <= key_row_n;
      key_col <= key_col_n;
      value   <= value_n;
      trig    <= trig_n;
      operand <= operand_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col;
    div_cnt_n = div_cnt;
    cnt_n     = cnt;
    key_row_n = key_row;
    key_col_n = key_col;
    value_n   = value;
    trig_n    = 1'b0;
    operand_n = operand;

    case (state)
      SCAN: begin
        // A hit freezes the column so the debounce keeps looking at the
        // same key. A stale rs right after a column step can latch the
        // wrong column; the debounce rejects it once rs catches up.
        if (one_low(rs)) begin
          key_row_n = rs;
          key_col_n = col;
          cnt_n     = '0;
          state_n   = DEBOUNCE;
        end else if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          col_n     = {col[2:0], col[3]};
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rs != key_row) begin
          state_n = SCAN;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt + 1'b1 == CNT_DONE) begin
            state_n = PRESSED;
          end
        end
      end

      PRESSED: begin
        value_n = key_code;
        trig_n  = 1'b1;
        if (key_code <= 4'd9) begin
          operand_n = {operand[3:0], key_code};
        end
        cnt_n   = '0;
        state_n = WAIT_RELEASE;
      end

      WAIT_RELEASE: begin
        if (rs == 4'hF) begin
          if (cnt + 1'b1 == CNT_DONE) begin
            cnt_n   = '0;
            state_n = SCAN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          cnt_n = '0;
        end
      end

      default: begin
        state_n = SCAN;
      end
    endcase

    // Entry clear overrides everything; parking in WAIT_RELEASE stops a key
    // held across the clear from being accepted again.
    if (!ClearIU) begin
      operand_n = 8'h00;
      value_n   = 4'h0;
      trig_n    = 1'b0;
      cnt_n     = '0;
      div_cnt_n = '0;
      col_n     = col;
      state_n   = WAIT_RELEASE;
    end
  end

endmodule
`default_nettype wire
